ff_edge_bank: RTL and testbench

- Reference bank of three parallel SIZE-bit flop styles, all driven by one data input: posedge capture, negedge capture, and a two-stage posedge pipeline.
- Serves as the golden model for flop-translation equivalence checks.
- Sits between random stimulus and comparison logic; purely sequential, no combinational path from d to any q.

---
 rtl/ff_edge_bank.sv | 37 +++
 tb/tb_ff_edge_bank.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ff_edge_bank.sv
// ff_edge_bank: posedge, negedge and two-stage posedge flop banks on one d; `FLOP_CLKEN_EN adds clock enable en
module ff_edge_bank #(
  parameter int SIZE = 1
) (
  input  logic            clk,
  input  logic            rst,
`ifdef FLOP_CLKEN_EN
  input  logic            en,
`endif
  input  logic [SIZE-1:0] d,
  output logic [SIZE-1:0] q1,
  output logic [SIZE-1:0] q2,
  output logic [SIZE-1:0] q3
);
  logic [SIZE-1:0] s3;
  logic            cap;
`ifdef FLOP_CLKEN_EN
  assign cap = (en === 1'b1);
`else
  assign cap = 1'b1;
`endif
  // rising-edge banks: direct capture plus the two-stage pipeline, which holds as a pair
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q1 <= '0;
      s3 <= '0;
      q3 <= '0;
    end else if (cap) begin
      q1 <= d;
      s3 <= d;
      q3 <= s3;
    end
  // falling-edge bank
  always_ff @(negedge clk or posedge rst)
    if (rst) q2 <= '0;
    else if (cap) q2 <= d;
endmodule

// File: tb/tb_ff_edge_bank.sv
// tb_ff_edge_bank: scoreboard bench for ff_edge_bank, SIZE=4 directed and SIZE=1 randomized
`timescale 1ns/100ps
module tb_ff_edge_bank;
  typedef struct {
    int         u;
    string      nm;
    logic [3:0] e1;
    logic [3:0] e2;
    logic [3:0] e3;
  } exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  logic       clk4 = 0, rst4 = 0;
  logic [3:0] d4 = 0;
  logic [3:0] q1_4, q2_4, q3_4;
  logic       clk1 = 0, rst1 = 0;
  logic [0:0] d1 = 0;
  logic [0:0] q1_1, q2_1, q3_1;
`ifdef FLOP_CLKEN_EN
  logic en = 1;
`endif
  ff_edge_bank #(.SIZE(4)) dut4 (
    .clk(clk4), .rst(rst4),
`ifdef FLOP_CLKEN_EN
    .en(en),
`endif
    .d(d4), .q1(q1_4), .q2(q2_4), .q3(q3_4));
  ff_edge_bank #(.SIZE(1)) dut1 (
    .clk(clk1), .rst(rst1),
`ifdef FLOP_CLKEN_EN
    .en(en),
`endif
    .d(d1), .q1(q1_1), .q2(q2_1), .q3(q3_1));
  // reference: last rising sample, the one before it, last falling sample
  logic [3:0] last_rise[2];
  logic [3:0] prev_rise[2];
  logic [3:0] last_fall[2];
  logic       cc[2];
  logic       rr[2];
  logic [3:0] dd[2];
  function automatic logic en_ok();
`ifdef FLOP_CLKEN_EN
    return en === 1'b1;
`else
    return 1'b1;
`endif
  endfunction
  task automatic apply(input int u, input logic c, input logic r, input logic [3:0] dv, input string nm);
    logic       oc;
    logic [3:0] v;
    oc = cc[u];
    v = (u == 0) ? dv : {3'b000, dv[0]};
    if (u == 0) begin
      clk4 = c; rst4 = r; d4 = v;
    end else begin
      clk1 = c; rst1 = r; d1 = v[0:0];
    end
    cc[u] = c; rr[u] = r; dd[u] = v;
    if (r) begin
      last_rise[u] = 0; prev_rise[u] = 0; last_fall[u] = 0;
    end else if (en_ok()) begin
      if (!oc && c) begin
        prev_rise[u] = last_rise[u];
        last_rise[u] = v;
      end
      if (oc && !c) last_fall[u] = v;
    end
    exp_q.push_back('{u, nm, last_rise[u], last_fall[u], prev_rise[u]});
    #1;
  endtask
  task automatic set_clk(input int u, input logic c, input string nm);
    apply(u, c, rr[u], dd[u], nm);
  endtask
  task automatic set_rst(input int u, input logic r, input string nm);
    apply(u, cc[u], r, dd[u], nm);
  endtask
  task automatic set_d(input int u, input logic [3:0] v, input string nm);
    apply(u, cc[u], rr[u], v, nm);
  endtask
  task automatic cyc(input int u, input string nm);
    set_clk(u, 1, nm);
    set_clk(u, 0, nm);
  endtask
  task automatic cmp(input string nm, input string which, input logic [3:0] a, input logic [3:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s %s got %b expected %b at %0t", nm, which, a, e, $time);
    end
  endtask
  // monitor: drains the scoreboard half a unit after each stimulus step
  initial begin
    exp_t e;
    #0.5;
    forever begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp(e.nm, "q1", e.u == 0 ? q1_4 : {3'b000, q1_1}, e.e1);
        cmp(e.nm, "q2", e.u == 0 ? q2_4 : {3'b000, q2_1}, e.e2);
        cmp(e.nm, "q3", e.u == 0 ? q3_4 : {3'b000, q3_1}, e.e3);
      end
      #1;
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end
  initial begin
    logic [3:0] xz;
    for (int u = 0; u < 2; u++) begin
      cc[u] = 0; rr[u] = 0; dd[u] = 0;
      last_rise[u] = 0; prev_rise[u] = 0; last_fall[u] = 0;
    end
    apply(0, 0, 1, 4'hF, "rst_assert");
    apply(1, 0, 1, 4'h1, "rst_assert1");
    for (int i = 0; i < 3; i++) cyc(0, "rst_hold");
    set_rst(0, 0, "rst_release");
    set_d(0, 4'hA, "load_a");
    set_clk(0, 1, "cap_a");
    set_rst(0, 1, "rst_async");
    set_rst(0, 0, "rst_release2");
    set_clk(0, 0, "fall_after_rst");
    set_d(0, 4'h5, "d5");
    set_clk(0, 1, "rise_5");
    set_d(0, 4'hC, "dC");
    set_clk(0, 0, "fall_C");
    set_rst(0, 1, "pipe_rst");
    set_rst(0, 0, "pipe_rel");
    set_d(0, 4'h3, "d3");
    cyc(0, "pipe_e1");
    set_d(0, 4'h9, "d9");
    cyc(0, "pipe_e2");
    cyc(0, "pipe_e3");
    xz = 4'b1xz0;
    set_d(0, xz, "dxz");
    cyc(0, "xz_e1");
    cyc(0, "xz_e2");
    cyc(0, "xz_e3");
`ifdef FLOP_CLKEN_EN
    en = 0;
    set_d(0, 4'h7, "en0_d7");
    cyc(0, "en0_hold");
    en = 1'bx;
    set_d(0, 4'h7, "enx_d7");
    cyc(0, "enx_hold");
    en = 1;
    set_d(0, 4'h7, "en1_d7");
    cyc(0, "en1_cap");
`endif
    set_rst(1, 0, "r1_release");
    for (int i = 0; i < 20000; i++) begin
      int k;
      k = $urandom_range(0, 19);
      if (k < 8) set_clk(1, ~cc[1], "rand_clk");
      else if (k < 17) set_d(1, {3'b000, $urandom_range(0, 1) == 1}, "rand_d");
      else if (k < 18) set_d(1, xz, "rand_dx");
      else if (k < 19) set_rst(1, $urandom_range(0, 7) == 0, "rand_rst");
      else set_d(1, dd[1], "rand_idle");
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
